// File: rtl/pipe_ctrl_pkg.sv
// Shared types and constants for the pipeline sequencing controller.
//   state_e  : controller FSM encoding (BOOT/RUN/FLUSH), also exported on state_o
//   HZ_*     : hazard codes presented by the hazard detector
//   ctrl_t   : bundle of enable/flush controls for the PC and pipeline registers
package pipe_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  localparam logic [1:0] HZ_NONE   = 2'd0;
  localparam logic [1:0] HZ_DATA   = 2'd1;
  localparam logic [1:0] HZ_BRANCH = 2'd2;

  typedef struct packed {
    logic pc_en;
    logic if_id_en;
    logic if_id_flush;
    logic id_ex_en;
    logic id_ex_flush;
    logic ex_mem_en;
    logic mem_wb_en;
  } ctrl_t;

  // Pipeline clear: everything held, front registers forced to NOP.
  localparam ctrl_t CTRL_BOOT   = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b1,
                                    id_ex_en: 1'b0, id_ex_flush: 1'b1,
                                    ex_mem_en: 1'b0, mem_wb_en: 1'b0};
  localparam ctrl_t CTRL_RUN    = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b0,
                                    id_ex_en: 1'b1, id_ex_flush: 1'b0,
                                    ex_mem_en: 1'b1, mem_wb_en: 1'b1};
  // Data hazard: hold PC and IF/ID, push a bubble into ID/EX.
  localparam ctrl_t CTRL_STALL  = '{pc_en: 1'b0, if_id_en: 1'b0, if_id_flush: 1'b0,
                                    id_ex_en: 1'b1, id_ex_flush: 1'b1,
                                    ex_mem_en: 1'b1, mem_wb_en: 1'b1};
  // Taken branch: PC loads the redirect target, the two front stages are squashed.
  localparam ctrl_t CTRL_BRANCH = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1,
                                    id_ex_en: 1'b1, id_ex_flush: 1'b1,
                                    ex_mem_en: 1'b1, mem_wb_en: 1'b1};

endpackage

// File: rtl/pipe_ctrl_sat_counter.sv
// Saturating up-counter used for the performance counters.
//   clk_i, rst_ni : clock, asynchronous active-low reset (clears the count)
//   clr_i         : synchronous clear, wins over inc_i
//   inc_i         : increment by one, sticks at all-ones
//   cnt_o         : current count
module sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clr_i,
  input  logic             inc_i,
  output logic [WIDTH-1:0] cnt_o
);

  logic [WIDTH-1:0] cnt_q;
  logic [WIDTH-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pipe_ctrl.sv
// Sequencing controller for a 5-stage non-forwarding RV32I pipeline.
// Turns the hazard detector's code and the LSU memory-busy freeze into
// enable/flush controls for the PC and the four pipeline registers, runs the
// post-reset pipeline clear and the multi-cycle branch flush, and keeps
// saturating stall/flush event counters.
//   clk_i, rst_ni      : clock, asynchronous active-low reset
//   hazard_op_i        : 0 none, 1 data hazard, 2/3 taken branch
//   mem_busy_i         : freeze the whole pipeline this cycle
//   *_en_o, *_flush_o  : register enables / clear-to-NOP controls (combinational)
//   stall_cnt_o        : data-stall cycles, saturating
//   flush_cnt_o        : taken-branch events, saturating
//   state_o            : current FSM state for debug
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int CNT_W        = 16
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [1:0]       hazard_op_i,
  input  logic             mem_busy_i,
  output logic             pc_en_o,
  output logic             if_id_en_o,
  output logic             if_id_flush_o,
  output logic             id_ex_en_o,
  output logic             id_ex_flush_o,
  output logic             ex_mem_en_o,
  output logic             mem_wb_en_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o,
  output logic [1:0]       state_o
);

  // Remaining FLUSH cycles after the branch cycle itself.
  localparam logic [2:0] FLUSH_RELOAD = 3'(FLUSH_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] flush_rem_q, flush_rem_d;
  ctrl_t      ctrl;
  logic       stall_inc;
  logic       flush_inc;
  logic       cnt_clr;

  always_comb begin
    state_d     = state_q;
    flush_rem_d = flush_rem_q;
    ctrl        = '0;
    stall_inc   = 1'b0;
    flush_inc   = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        ctrl    = CTRL_BOOT;
        state_d = ST_RUN;
      end

      ST_RUN: begin
        // A freeze leaves ctrl all-zero and every piece of state untouched.
        if (!mem_busy_i) begin
          if (hazard_op_i[1]) begin
            ctrl      = CTRL_BRANCH;
            flush_inc = 1'b1;
            if (FLUSH_CYCLES > 1) begin
              state_d     = ST_FLUSH;
              flush_rem_d = FLUSH_RELOAD;
            end
          end else if (hazard_op_i == HZ_DATA) begin
            ctrl      = CTRL_STALL;
            stall_inc = 1'b1;
          end else begin
            ctrl = CTRL_RUN;
          end
        end
      end

      ST_FLUSH: begin
        // Data hazards are dropped here: the stale ID operands are being squashed anyway.
        if (!mem_busy_i) begin
          ctrl = CTRL_BRANCH;
          if (hazard_op_i[1]) begin
            flush_rem_d = FLUSH_RELOAD;
            flush_inc   = 1'b1;
          end else begin
            flush_rem_d = flush_rem_q - 3'd1;
            if (flush_rem_q == 3'd1) begin
              state_d = ST_RUN;
            end
          end
        end
      end

      default: begin
        state_d = ST_BOOT;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= ST_BOOT;
      flush_rem_q <= 3'd0;
    end else begin
      state_q     <= state_d;
      flush_rem_q <= flush_rem_d;
    end
  end

  // Every pipeline clear starts the event counters from zero.
  assign cnt_clr = (state_q == ST_BOOT);

  sat_counter #(.WIDTH(CNT_W)) u_stall_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .inc_i  (stall_inc),
    .cnt_o  (stall_cnt_o)
  );

  sat_counter #(.WIDTH(CNT_W)) u_flush_cnt (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .clr_i  (cnt_clr),
    .inc_i  (flush_inc),
    .cnt_o  (flush_cnt_o)
  );

  assign pc_en_o       = ctrl.pc_en;
  assign if_id_en_o    = ctrl.if_id_en;
  assign if_id_flush_o = ctrl.if_id_flush;
  assign id_ex_en_o    = ctrl.id_ex_en;
  assign id_ex_flush_o = ctrl.id_ex_flush;
  assign ex_mem_en_o   = ctrl.ex_mem_en;
  assign mem_wb_en_o   = ctrl.mem_wb_en;
  assign state_o       = state_q;

endmodule
